// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the physical-memory arbiter.
//
// Contents:
//   pmem_arb_state_t  arbiter FSM states
//   requester_t       which side holds (or last held) the memory port
//   line_t / addr_t   line and address types at the default widths
//   tieWinner()       picks the winner when both sides request in IDLE
//
// Build option: define PMEM_ARB_ROUND_ROBIN_EN to alternate the winner of
// contested requests. Without it, the data side always wins a tie.
package pmem_arb_types;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 32;
  localparam int unsigned DEFAULT_LINE_WIDTH = 256;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  localparam bit ROUND_ROBIN_EN = 1'b1;
`else
  localparam bit ROUND_ROBIN_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    RELEASE
  } pmem_arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } requester_t;

  typedef logic [DEFAULT_LINE_WIDTH-1:0] line_t;
  typedef logic [DEFAULT_ADDR_WIDTH-1:0] addr_t;

  // With round-robin, the side that did not hold the port last wins.
  // Otherwise the data side wins, so a dirty write-back is never starved
  // by back-to-back instruction fetches.
  function automatic requester_t tieWinner(input requester_t lastGrant,
                                           input bit rrEn);
    if (!rrEn) begin
      return REQ_D;
    end
    return (lastGrant == REQ_D) ? REQ_I : REQ_D;
  endfunction

endpackage

// File: rtl/pmem_arbiter_control.sv
// Arbitration FSM for the physical-memory port, plus the last_grant record.
//
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   iReq_i           I-cache is requesting a line read
//   dReq_i           data side is requesting a line read or write
//   pmemResp_i       memory finished the current transfer
//   grantI_o         I-cache owns the memory port this cycle
//   grantD_o         data side owns the memory port this cycle
//
// Build option: PMEM_ARB_ROUND_ROBIN_EN (see pmem_arb_types).
module pmem_arbiter_control
  import pmem_arb_types::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic iReq_i,
  input  logic dReq_i,
  input  logic pmemResp_i,
  output logic grantI_o,
  output logic grantD_o
);

  pmem_arb_state_t state_q, state_d;
  requester_t      lastGrant_q, lastGrant_d;

  // State and last_grant registers. last_grant resets to D so that the
  // first contested grant under round-robin goes to the I-cache.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      lastGrant_q <= REQ_D;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
    end
  end

  // Next-state logic. A grant is held for the whole line transfer; the
  // response takes priority over a dropped request in the same cycle,
  // because a well-behaved requester holds its request until resp.
  // RELEASE gives the requester one quiet cycle to change its request.
  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    case (state_q)
      IDLE: begin
        if (iReq_i && dReq_i) begin
          if (tieWinner(lastGrant_q, ROUND_ROBIN_EN) == REQ_I) begin
            state_d     = GRANT_I;
            lastGrant_d = REQ_I;
          end else begin
            state_d     = GRANT_D;
            lastGrant_d = REQ_D;
          end
        end else if (dReq_i) begin
          state_d     = GRANT_D;
          lastGrant_d = REQ_D;
        end else if (iReq_i) begin
          state_d     = GRANT_I;
          lastGrant_d = REQ_I;
        end
      end
      GRANT_I: begin
        if (pmemResp_i) begin
          state_d = RELEASE;
        end else if (!iReq_i) begin
          state_d = IDLE;
        end
      end
      GRANT_D: begin
        if (pmemResp_i) begin
          state_d = RELEASE;
        end else if (!dReq_i) begin
          state_d = IDLE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign grantI_o = (state_q == GRANT_I);
  assign grantD_o = (state_q == GRANT_D);

endmodule

// File: rtl/pmem_arbiter.sv
// Two-requester arbiter sharing one physical-memory port between the
// I-cache and the data side (victim cache control). One grant covers a
// whole line transfer; the memory response goes only to the granted side.
//
// Ports:
//   clk, rst                                 clock, sync active-high reset
//   i_pmem_read/address, i_pmem_rdata/resp   I-cache side
//   d_pmem_read/write/address/wdata,
//   d_pmem_rdata/resp                        data side
//   pmem_read/write/address/wdata,
//   pmem_rdata/resp                          physical memory
//
// Build option: define PMEM_ARB_ROUND_ROBIN_EN for round-robin tie
// breaking; the default build gives ties to the data side.
module pmem_arbiter
  import pmem_arb_types::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned LINE_WIDTH = DEFAULT_LINE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  logic grantI;
  logic grantD;

  pmem_arbiter_control u_control (
    .clk_i      (clk),
    .rst_i      (rst),
    .iReq_i     (i_pmem_read),
    .dReq_i     (d_pmem_read | d_pmem_write),
    .pmemResp_i (pmem_resp),
    .grantI_o   (grantI),
    .grantD_o   (grantD)
  );

  // Command mux. Nothing is latched: the owner must keep its request and
  // address stable until resp. A write beats a simultaneous read on the
  // data side (that combination is a protocol violation).
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    if (grantI) begin
      pmem_read    = i_pmem_read;
      pmem_address = i_pmem_address;
    end else if (grantD) begin
      pmem_read    = d_pmem_read & ~d_pmem_write;
      pmem_write   = d_pmem_write;
      pmem_address = d_pmem_address;
      pmem_wdata   = d_pmem_wdata;
    end
  end

  // Response steering is combinational; a resp outside a grant is dropped.
  assign i_pmem_resp  = grantI & pmem_resp;
  assign d_pmem_resp  = grantD & pmem_resp;

  // Both sides see memory read data; each qualifies it with its own resp.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed self-checking bench for pmem_arbiter. Inputs change at the
// falling clock edge; outputs are sampled 1 ns later, well away from the
// rising edge that moves the FSM.
module tb_pmem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_pmem_read = 1'b0;
  logic [AW-1:0] i_pmem_address = '0;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read = 1'b0;
  logic          d_pmem_write = 1'b0;
  logic [AW-1:0] d_pmem_address = '0;
  logic [LW-1:0] d_pmem_wdata = '0;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  // Expected contention winners: round-robin alternates starting with I,
  // fixed priority always picks D.
`ifdef PMEM_ARB_ROUND_ROBIN_EN
  localparam bit C1_FIRST_D = 1'b0;
  localparam bit C2_FIRST_D = 1'b0;
  localparam bit C3_FIRST_D = 1'b1;
`else
  localparam bit C1_FIRST_D = 1'b1;
  localparam bit C2_FIRST_D = 1'b1;
  localparam bit C3_FIRST_D = 1'b1;
`endif

  // Reset with junk on the data-side inputs and a stray memory resp:
  // everything toward memory and both resps must read zero.
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    d_pmem_address = 32'hFFFF_0000;
    d_pmem_wdata = {8{32'h1234_5678}};
    pmem_resp = 1'b1;
    @(negedge clk); #1;
    nChecks++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_cmd: read/write got %b%b want 00", pmem_read, pmem_write);
    end
    nChecks++;
    if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_resp: i/d resp got %b%b want 00", i_pmem_resp, d_pmem_resp);
    end
    nChecks++;
    if (pmem_address !== 32'h0 || pmem_wdata !== '0) begin
      nFails++;
      $display("[TB] FAIL reset_addr_wdata: addr got %h want 0, wdata nonzero=%b", pmem_address, |pmem_wdata);
    end
    rst = 1'b0;
    pmem_resp = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata = '0;
  endtask

  // Lone I read at 0x1000; memory answers in the 4th command cycle and
  // keeps resp high into RELEASE, where it must be ignored.
  task automatic test_lone_i_read();
    logic [LW-1:0] line;
    line = {8{32'hA5A5_0001}};
    @(negedge clk);
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1000; #1;
    nChecks++;
    if (pmem_read !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL lone_arb_cycle: pmem_read got %b want 0", pmem_read);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 3) begin
        pmem_resp = 1'b1; pmem_rdata = line;
      end
      #1;
      nChecks++;
      if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_1000) begin
        nFails++;
        $display("[TB] FAIL lone_cmd[%0d]: read %b addr %h want 1 00001000", k, pmem_read, pmem_address);
      end
      nChecks++;
      if (i_pmem_resp !== (k == 3) || d_pmem_resp !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL lone_resp[%0d]: i/d resp got %b%b want %b0", k, i_pmem_resp, d_pmem_resp, (k == 3));
      end
    end
    nChecks++;
    if (i_pmem_rdata !== line) begin
      nFails++;
      $display("[TB] FAIL lone_rdata: got %h want %h", i_pmem_rdata[31:0], line[31:0]);
    end
    @(negedge clk); #1;
    nChecks++;
    if (pmem_read !== 1'b0 || i_pmem_resp !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL lone_release: read %b resp %b want 0 0", pmem_read, i_pmem_resp);
    end
    i_pmem_read = 1'b0; pmem_resp = 1'b0;
    @(negedge clk); #1;
    nChecks++;
    if (pmem_read !== 1'b0 || pmem_address !== 32'h0) begin
      nFails++;
      $display("[TB] FAIL lone_idle: read %b addr %h want 0 0", pmem_read, pmem_address);
    end
  endtask

  // Victim write-back to 0x2000 then line read from 0x3000. The read is
  // presented during RELEASE, so it reaches memory 3 cycles after resp.
  task automatic test_dirty_eviction();
    logic [LW-1:0] wline;
    int dResps;
    wline = {8{32'hDEAD_BEEF}};
    dResps = 0;
    @(negedge clk);
    d_pmem_write = 1'b1; d_pmem_address = 32'h0000_2000; d_pmem_wdata = wline; #1;
    nChecks++;
    if (pmem_write !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL evict_arb_cycle: pmem_write got %b want 0", pmem_write);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      pmem_resp = (k == 1); #1;
      dResps += int'(d_pmem_resp);
      nChecks++;
      if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 32'h0000_2000) begin
        nFails++;
        $display("[TB] FAIL evict_wr_cmd[%0d]: w %b r %b addr %h want 1 0 00002000", k, pmem_write, pmem_read, pmem_address);
      end
      nChecks++;
      if (pmem_wdata !== wline) begin
        nFails++;
        $display("[TB] FAIL evict_wdata[%0d]: got %h want %h", k, pmem_wdata[31:0], wline[31:0]);
      end
    end
    @(negedge clk);
    pmem_resp = 1'b0;
    d_pmem_write = 1'b0; d_pmem_read = 1'b1; d_pmem_address = 32'h0000_3000; #1;
    dResps += int'(d_pmem_resp);
    nChecks++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL evict_release: r/w got %b%b want 00", pmem_read, pmem_write);
    end
    @(negedge clk); #1;
    dResps += int'(d_pmem_resp);
    nChecks++;
    if (pmem_read !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL evict_idle: pmem_read got %b want 0", pmem_read);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      pmem_resp = (k == 2); pmem_rdata = {8{32'hC0DE_0003}}; #1;
      dResps += int'(d_pmem_resp);
      nChecks++;
      if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 32'h0000_3000) begin
        nFails++;
        $display("[TB] FAIL evict_rd_cmd[%0d]: r %b w %b addr %h want 1 0 00003000", k, pmem_read, pmem_write, pmem_address);
      end
    end
    @(negedge clk);
    pmem_resp = 1'b0; d_pmem_read = 1'b0; #1;
    dResps += int'(d_pmem_resp);
    nChecks++;
    if (dResps !== 2) begin
      nFails++;
      $display("[TB] FAIL evict_resp_count: got %0d want 2", dResps);
    end
    @(negedge clk);
  endtask

  // Both sides request 0x4000 (I) / 0x5000 (D) in IDLE. The winner gets
  // one response; with serveBoth the loser keeps requesting and is
  // granted after the winner's RELEASE, otherwise both drop.
  task automatic test_contention(input string tag, input bit firstIsD, input bit serveBoth);
    logic [AW-1:0] winAddr, loseAddr;
    winAddr  = firstIsD ? 32'h0000_5000 : 32'h0000_4000;
    loseAddr = firstIsD ? 32'h0000_4000 : 32'h0000_5000;
    @(negedge clk);
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_4000;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_5000; #1;
    nChecks++;
    if (pmem_read !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL %s_arb_cycle: pmem_read got %b want 0", tag, pmem_read);
    end
    @(negedge clk);
    pmem_resp = 1'b1; #1;
    nChecks++;
    if (pmem_read !== 1'b1 || pmem_address !== winAddr) begin
      nFails++;
      $display("[TB] FAIL %s_winner: read %b addr %h want 1 %h", tag, pmem_read, pmem_address, winAddr);
    end
    nChecks++;
    if (i_pmem_resp !== !firstIsD || d_pmem_resp !== firstIsD) begin
      nFails++;
      $display("[TB] FAIL %s_winner_resp: i/d got %b%b want %b%b", tag, i_pmem_resp, d_pmem_resp, !firstIsD, firstIsD);
    end
    @(negedge clk);
    pmem_resp = 1'b0;
    if (firstIsD || !serveBoth) d_pmem_read = 1'b0;
    if (!firstIsD || !serveBoth) i_pmem_read = 1'b0;
    #1;
    nChecks++;
    if (pmem_read !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL %s_release: pmem_read got %b want 0", tag, pmem_read);
    end
    @(negedge clk);
    if (serveBoth) begin
      @(negedge clk);
      pmem_resp = 1'b1; #1;
      nChecks++;
      if (pmem_read !== 1'b1 || pmem_address !== loseAddr) begin
        nFails++;
        $display("[TB] FAIL %s_second: read %b addr %h want 1 %h", tag, pmem_read, pmem_address, loseAddr);
      end
      nChecks++;
      if (i_pmem_resp !== firstIsD || d_pmem_resp !== !firstIsD) begin
        nFails++;
        $display("[TB] FAIL %s_second_resp: i/d got %b%b want %b%b", tag, i_pmem_resp, d_pmem_resp, firstIsD, !firstIsD);
      end
      @(negedge clk);
      pmem_resp = 1'b0; i_pmem_read = 1'b0; d_pmem_read = 1'b0;
      @(negedge clk);
    end
  endtask

  // Reset two cycles into a D read: the command must vanish and a stray
  // resp must not reach the data side; the next request then sees the
  // normal one-cycle arbitration delay from IDLE.
  task automatic test_reset_mid_transfer();
    @(negedge clk);
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_6000;
    @(negedge clk); #1;
    nChecks++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_6000) begin
      nFails++;
      $display("[TB] FAIL rstmid_grant: read %b addr %h want 1 00006000", pmem_read, pmem_address);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b1; #1;
    nChecks++;
    if (pmem_read !== 1'b0 || d_pmem_resp !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL rstmid_drop: read %b d_resp %b want 0 0", pmem_read, d_pmem_resp);
    end
    rst = 1'b0; pmem_resp = 1'b0; d_pmem_read = 1'b0;
    @(negedge clk);
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_6100; #1;
    nChecks++;
    if (pmem_read !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL rstmid_idle: pmem_read got %b want 0", pmem_read);
    end
    @(negedge clk); #1;
    nChecks++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_6100) begin
      nFails++;
      $display("[TB] FAIL rstmid_regrant: read %b addr %h want 1 00006100", pmem_read, pmem_address);
    end
    i_pmem_read = 1'b0;
    @(negedge clk);
  endtask

  // Granted I drops its request before resp: no resp, back to IDLE, so a
  // late resp is ignored and a new D request is granted one cycle later.
  task automatic test_abort();
    @(negedge clk);
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_7000;
    @(negedge clk); #1;
    nChecks++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_7000) begin
      nFails++;
      $display("[TB] FAIL abort_grant: read %b addr %h want 1 00007000", pmem_read, pmem_address);
    end
    @(negedge clk);
    i_pmem_read = 1'b0; #1;
    nChecks++;
    if (pmem_read !== 1'b0 || i_pmem_resp !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL abort_drop: read %b i_resp %b want 0 0", pmem_read, i_pmem_resp);
    end
    @(negedge clk);
    pmem_resp = 1'b1; d_pmem_read = 1'b1; d_pmem_address = 32'h0000_8000; #1;
    nChecks++;
    if (pmem_read !== 1'b0 || i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL abort_idle: read %b i/d resp %b%b want 0 00", pmem_read, i_pmem_resp, d_pmem_resp);
    end
    @(negedge clk); #1;
    nChecks++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_8000 || d_pmem_resp !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL abort_next: read %b addr %h d_resp %b want 1 00008000 1", pmem_read, pmem_address, d_pmem_resp);
    end
    @(negedge clk);
    pmem_resp = 1'b0; d_pmem_read = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_lone_i_read();
    test_dirty_eviction();
    test_reset();
    test_contention("cont1", C1_FIRST_D, 1'b1);
    test_contention("cont2", C2_FIRST_D, 1'b0);
    test_contention("cont3", C3_FIRST_D, 1'b0);
    test_reset_mid_transfer();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1);
  end

endmodule
